// File: rtl/id_exe_hazard_stage.sv
// ID/EXE pipeline register with load-use / RAW hazard detection.
// It inserts bubbles into EXE and drives the stall that freezes PC and IF/ID.
module id_exe_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CMD_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              forward_en,
  input  logic              flush,
  input  logic              freeze,
  input  logic [REG_W-1:0]  src1_ID,
  input  logic [REG_W-1:0]  src2_ID,
  input  logic [REG_W-1:0]  ST_src_ID,
  input  logic              two_src_ID,
  input  logic [REG_W-1:0]  dest_ID,
  input  logic [DATA_W-1:0] val1_ID,
  input  logic [DATA_W-1:0] val2_ID,
  input  logic [DATA_W-1:0] ST_val_ID,
  input  logic [CMD_W-1:0]  EXE_CMD_ID,
  input  logic              MEM_R_EN_ID,
  input  logic              MEM_W_EN_ID,
  input  logic              WB_EN_ID,
  input  logic [REG_W-1:0]  dest_MEM,
  input  logic              WB_EN_MEM,
  output logic [REG_W-1:0]  src1_EXE,
  output logic [REG_W-1:0]  src2_EXE,
  output logic [REG_W-1:0]  ST_src_EXE,
  output logic [REG_W-1:0]  dest_EXE,
  output logic [DATA_W-1:0] val1_EXE,
  output logic [DATA_W-1:0] val2_EXE,
  output logic [DATA_W-1:0] ST_val_EXE,
  output logic [CMD_W-1:0]  EXE_CMD_EXE,
  output logic              MEM_R_EN_EXE,
  output logic              MEM_W_EN_EXE,
  output logic              WB_EN_EXE,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic [REG_W-1:0]  st_src;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] st_val;
    logic [CMD_W-1:0]  cmd;
    logic              mem_r;
    logic              mem_w;
    logic              wb;
  } exe_t;

  exe_t exe_q, id_d;

  always_comb begin
    id_d        = '0;
    id_d.src1   = src1_ID;
    id_d.src2   = src2_ID;
    id_d.st_src = ST_src_ID;
    id_d.dest   = dest_ID;
    id_d.val1   = val1_ID;
    id_d.val2   = val2_ID;
    id_d.st_val = ST_val_ID;
    id_d.cmd    = EXE_CMD_ID;
    id_d.mem_r  = MEM_R_EN_ID;
    id_d.mem_w  = MEM_W_EN_ID;
    // $zero writes never become forwarding sources downstream
    id_d.wb     = WB_EN_ID && (dest_ID != '0);
  end

  logic m1, m2, ms, hit_exe, hit_mem, raw_stall;

  function automatic logic hit(input logic [REG_W-1:0] d, input logic en,
                               input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                               input logic [REG_W-1:0] c, input logic ea,
                               input logic eb, input logic ec);
    return en && (d != '0) && ((ea && a == d) || (eb && b == d) || (ec && c == d));
  endfunction

  always_comb begin
    m1        = src1_ID != '0;
    m2        = two_src_ID && (src2_ID != '0);
    ms        = MEM_W_EN_ID && (ST_src_ID != '0);
    hit_exe   = hit(exe_q.dest, exe_q.wb, src1_ID, src2_ID, ST_src_ID, m1, m2, ms);
    hit_mem   = hit(dest_MEM, WB_EN_MEM, src1_ID, src2_ID, ST_src_ID, m1, m2, ms);
    raw_stall = forward_en ? (hit_exe && exe_q.mem_r) : (hit_exe || hit_mem);
    // a flushed instruction is discarded anyway, so it must not stall
    stall     = raw_stall && !flush && rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_q     <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      if (flush || stall) begin
        exe_q <= '0;
        if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        exe_q <= id_d;
      end
    end
  end

  assign src1_EXE     = exe_q.src1;
  assign src2_EXE     = exe_q.src2;
  assign ST_src_EXE   = exe_q.st_src;
  assign dest_EXE     = exe_q.dest;
  assign val1_EXE     = exe_q.val1;
  assign val2_EXE     = exe_q.val2;
  assign ST_val_EXE   = exe_q.st_val;
  assign EXE_CMD_EXE  = exe_q.cmd;
  assign MEM_R_EN_EXE = exe_q.mem_r;
  assign MEM_W_EN_EXE = exe_q.mem_w;
  assign WB_EN_EXE    = exe_q.wb;

endmodule

// File: tb/tb_id_exe_hazard_stage.sv
// Bench for id_exe_hazard_stage: directed vector table, randomized run
// against a reference model, and a stall counter saturation sequence.
module tb_id_exe_hazard_stage;

  logic        clk = 0;
  logic        rst, forward_en, flush, freeze;
  logic [4:0]  src1_ID, src2_ID, ST_src_ID, dest_ID, dest_MEM;
  logic        two_src_ID, MEM_R_EN_ID, MEM_W_EN_ID, WB_EN_ID, WB_EN_MEM;
  logic [31:0] val1_ID, val2_ID, ST_val_ID;
  logic [3:0]  EXE_CMD_ID;
  logic [4:0]  src1_EXE, src2_EXE, ST_src_EXE, dest_EXE;
  logic [31:0] val1_EXE, val2_EXE, ST_val_EXE;
  logic [3:0]  EXE_CMD_EXE;
  logic        MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_exe_hazard_stage dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .flush(flush), .freeze(freeze),
    .src1_ID(src1_ID), .src2_ID(src2_ID), .ST_src_ID(ST_src_ID), .two_src_ID(two_src_ID),
    .dest_ID(dest_ID), .val1_ID(val1_ID), .val2_ID(val2_ID), .ST_val_ID(ST_val_ID),
    .EXE_CMD_ID(EXE_CMD_ID), .MEM_R_EN_ID(MEM_R_EN_ID), .MEM_W_EN_ID(MEM_W_EN_ID),
    .WB_EN_ID(WB_EN_ID), .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM),
    .src1_EXE(src1_EXE), .src2_EXE(src2_EXE), .ST_src_EXE(ST_src_EXE), .dest_EXE(dest_EXE),
    .val1_EXE(val1_EXE), .val2_EXE(val2_EXE), .ST_val_EXE(ST_val_EXE),
    .EXE_CMD_EXE(EXE_CMD_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
    .WB_EN_EXE(WB_EN_EXE), .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    bit         r, f, fl, fz;
    logic [4:0] s1, s2;
    bit         two;
    logic [4:0] dst;
    bit         rd, wr, wb;
    logic [4:0] dm;
    bit         wbm;
    bit         e_stall;
    logic [4:0] e_dest;
    bit         e_wb;
    logic [4:0] e_s1;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(string n, bit r, bit f, bit fl, bit fz, int s1, int s2, bit two,
                              int dst, bit rd, bit wr, bit wb, int dm, bit wbm,
                              bit es, int ed, bit ew, int es1, int ec);
    vec_t v;
    v.name = n; v.r = r; v.f = f; v.fl = fl; v.fz = fz;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.two = two; v.dst = 5'(dst);
    v.rd = rd; v.wr = wr; v.wb = wb; v.dm = 5'(dm); v.wbm = wbm;
    v.e_stall = es; v.e_dest = 5'(ed); v.e_wb = ew; v.e_s1 = 5'(es1); v.e_cnt = 16'(ec);
    return v;
  endfunction

  // reference state of the EXE stage, advanced from the spec's update rules
  typedef struct {
    logic [4:0]  s1, s2, sts, dst;
    logic [31:0] v1, v2, sv;
    logic [3:0]  cmd;
    logic        rd, wr, wb;
  } exe_m_t;

  exe_m_t m;
  int     m_cnt;

  function automatic bit ref_stall();
    int  reads[$];
    bit  exe_hit, mem_hit;
    if (!rst || flush) return 0;
    if (src1_ID != 0) reads.push_back(src1_ID);
    if (two_src_ID && src2_ID != 0) reads.push_back(src2_ID);
    if (MEM_W_EN_ID && ST_src_ID != 0) reads.push_back(ST_src_ID);
    exe_hit = 0; mem_hit = 0;
    foreach (reads[i]) begin
      if (m.wb && m.dst != 0 && reads[i] == m.dst) exe_hit = 1;
      if (WB_EN_MEM && dest_MEM != 0 && reads[i] == dest_MEM) mem_hit = 1;
    end
    return forward_en ? (exe_hit && m.rd) : (exe_hit || mem_hit);
  endfunction

  task automatic model_edge(input bit st);
    if (!rst) begin
      m = '{default: '0}; m_cnt = 0;
    end else if (!freeze) begin
      if (flush || st) begin
        m = '{default: '0};
        if (st && m_cnt < 65535) m_cnt++;
      end else begin
        m.s1 = src1_ID; m.s2 = src2_ID; m.sts = ST_src_ID; m.dst = dest_ID;
        m.v1 = val1_ID; m.v2 = val2_ID; m.sv = ST_val_ID; m.cmd = EXE_CMD_ID;
        m.rd = MEM_R_EN_ID; m.wr = MEM_W_EN_ID; m.wb = WB_EN_ID && dest_ID != 0;
      end
    end
  endtask

  vec_t tbl[$];
  bit   es;

  initial begin
    rst = 0; forward_en = 0; flush = 0; freeze = 0;
    src1_ID = 0; src2_ID = 0; ST_src_ID = 0; dest_ID = 0; dest_MEM = 0;
    two_src_ID = 0; MEM_R_EN_ID = 0; MEM_W_EN_ID = 0; WB_EN_ID = 0; WB_EN_MEM = 0;
    val1_ID = 0; val2_ID = 0; ST_val_ID = 0; EXE_CMD_ID = 0;

    //                   name       r f fl fz s1 s2 2 dst rd wr wb dm wbm | st dst wb s1 cnt
    tbl.push_back(mk("rst_a",     0,0,0,0, 5,7,1,9, 1,1,1, 5,1, 0,0,0,0,0));
    tbl.push_back(mk("rst_b",     0,0,0,0, 5,7,1,9, 1,1,1, 5,1, 0,0,0,0,0));
    tbl.push_back(mk("lw_fwd",    1,1,0,0, 1,0,0,5, 1,0,1, 0,0, 0,5,1,1,0));
    tbl.push_back(mk("lu_stall",  1,1,0,0, 5,0,0,6, 0,0,1, 0,0, 1,0,0,0,1));
    tbl.push_back(mk("lu_go",     1,1,0,0, 5,0,0,6, 0,0,1, 0,0, 0,6,1,5,1));
    tbl.push_back(mk("nop_a",     1,1,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,1));
    tbl.push_back(mk("add3",      1,0,0,0, 1,0,0,3, 0,0,1, 0,0, 0,3,1,1,1));
    tbl.push_back(mk("raw_b1",    1,0,0,0, 2,3,1,4, 0,0,1, 0,0, 1,0,0,0,2));
    tbl.push_back(mk("raw_b2",    1,0,0,0, 2,3,1,4, 0,0,1, 3,1, 1,0,0,0,3));
    tbl.push_back(mk("raw_go",    1,0,0,0, 2,3,1,4, 0,0,1, 0,0, 0,4,1,2,3));
    tbl.push_back(mk("nop_b",     1,0,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,3));
    tbl.push_back(mk("add3b",     1,0,0,0, 1,0,0,3, 0,0,1, 0,0, 0,3,1,1,3));
    tbl.push_back(mk("one_src",   1,0,0,0, 2,3,0,4, 0,0,1, 0,0, 0,4,1,2,3));
    tbl.push_back(mk("add7",      1,0,0,0, 1,0,0,7, 0,0,1, 3,1, 0,7,1,1,3));
    tbl.push_back(mk("gap",       1,0,0,0, 0,0,0,0, 0,0,0, 4,1, 0,0,0,0,3));
    tbl.push_back(mk("dep2",      1,0,0,0, 7,0,0,8, 0,0,1, 7,1, 1,0,0,0,4));
    tbl.push_back(mk("dep2_go",   1,0,0,0, 7,0,0,8, 0,0,1, 0,0, 0,8,1,7,4));
    tbl.push_back(mk("nop_c",     1,1,0,0, 0,0,0,0, 0,0,0, 0,0, 0,0,0,0,4));
    tbl.push_back(mk("lw_r0",     1,1,0,0, 1,0,0,0, 1,0,1, 0,0, 0,0,0,1,4));
    tbl.push_back(mk("add_r0",    1,1,0,0, 0,0,0,6, 0,0,1, 0,0, 0,6,1,0,4));
    tbl.push_back(mk("lw_fl",     1,1,0,0, 1,0,0,5, 1,0,1, 0,0, 0,5,1,1,4));
    tbl.push_back(mk("flush_st",  1,1,1,0, 5,0,0,6, 0,0,1, 0,0, 0,0,0,0,4));
    tbl.push_back(mk("lw_fz",     1,1,0,0, 1,0,0,5, 1,0,1, 0,0, 0,5,1,1,4));
    tbl.push_back(mk("frz1",      1,1,0,1, 5,0,0,6, 0,0,1, 0,0, 1,5,1,1,4));
    tbl.push_back(mk("frz2",      1,1,0,1, 5,0,0,6, 0,0,1, 0,0, 1,5,1,1,4));
    tbl.push_back(mk("frz3",      1,1,0,1, 5,0,0,6, 0,0,1, 0,0, 1,5,1,1,4));
    tbl.push_back(mk("frz_rel",   1,1,0,0, 5,0,0,6, 0,0,1, 0,0, 1,0,0,0,5));
    tbl.push_back(mk("frz_go",    1,1,0,0, 5,0,0,6, 0,0,1, 0,0, 0,6,1,5,5));
    tbl.push_back(mk("lw_rst",    1,1,0,0, 1,0,0,5, 1,0,1, 0,0, 0,5,1,1,5));
    tbl.push_back(mk("rst_mid",   0,1,0,0, 5,0,0,6, 0,0,1, 0,0, 0,0,0,0,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; forward_en = tbl[i].f; flush = tbl[i].fl; freeze = tbl[i].fz;
      src1_ID = tbl[i].s1; src2_ID = tbl[i].s2; two_src_ID = tbl[i].two; ST_src_ID = 0;
      dest_ID = tbl[i].dst; MEM_R_EN_ID = tbl[i].rd; MEM_W_EN_ID = tbl[i].wr;
      WB_EN_ID = tbl[i].wb; dest_MEM = tbl[i].dm; WB_EN_MEM = tbl[i].wbm;
      val1_ID = $urandom; val2_ID = $urandom; ST_val_ID = $urandom;
      EXE_CMD_ID = 4'($urandom);
      #1 chk({tbl[i].name, ".stall"}, 64'(stall), 64'(tbl[i].e_stall));
      @(posedge clk); #1;
      chk({tbl[i].name, ".dest"}, 64'(dest_EXE), 64'(tbl[i].e_dest));
      chk({tbl[i].name, ".wb"}, 64'(WB_EN_EXE), 64'(tbl[i].e_wb));
      chk({tbl[i].name, ".src1"}, 64'(src1_EXE), 64'(tbl[i].e_s1));
      chk({tbl[i].name, ".cnt"}, 64'(stall_cnt), 64'(tbl[i].e_cnt));
    end
    // the last vector resets the block, so the model starts empty
    chk("rst_mid.val1", 64'(val1_EXE), 64'd0);
    chk("rst_mid.rd", 64'(MEM_R_EN_EXE), 64'd0);
    m = '{default: '0}; m_cnt = 0;

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) != 0);
      forward_en = $urandom_range(0, 1);
      flush = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 5) == 0);
      src1_ID = 5'($urandom_range(0, 3)); src2_ID = 5'($urandom_range(0, 3));
      ST_src_ID = 5'($urandom_range(0, 3)); dest_ID = 5'($urandom_range(0, 3));
      dest_MEM = 5'($urandom_range(0, 3));
      two_src_ID = $urandom_range(0, 1); MEM_R_EN_ID = $urandom_range(0, 1);
      MEM_W_EN_ID = $urandom_range(0, 1); WB_EN_ID = $urandom_range(0, 1);
      WB_EN_MEM = $urandom_range(0, 1);
      val1_ID = $urandom; val2_ID = $urandom; ST_val_ID = $urandom;
      EXE_CMD_ID = 4'($urandom);
      #1;
      es = ref_stall();
      chk("rnd.stall", 64'(stall), 64'(es));
      model_edge(es);
      @(posedge clk); #1;
      chk("rnd.src", {src1_EXE, src2_EXE, ST_src_EXE, dest_EXE}, {m.s1, m.s2, m.sts, m.dst});
      chk("rnd.val1", 64'(val1_EXE), 64'(m.v1));
      chk("rnd.val2_st", {val2_EXE, ST_val_EXE}, {m.v2, m.sv});
      chk("rnd.ctl", {EXE_CMD_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE},
          {m.cmd, m.rd, m.wr, m.wb});
      chk("rnd.cnt", 64'(stall_cnt), 64'(m_cnt));
    end

    // a MEM-stage RAW with forwarding off stalls every cycle: drive the counter to its ceiling
    @(negedge clk);
    rst = 1; forward_en = 0; flush = 0; freeze = 0;
    src1_ID = 3; src2_ID = 0; ST_src_ID = 0; two_src_ID = 0; dest_ID = 0;
    MEM_R_EN_ID = 0; MEM_W_EN_ID = 0; WB_EN_ID = 0; dest_MEM = 3; WB_EN_MEM = 1;
    repeat (65600) @(posedge clk);
    @(negedge clk);
    chk("sat.stall", 64'(stall), 64'd1);
    chk("sat.cnt", 64'(stall_cnt), 64'hFFFF);
    freeze = 1;
    @(posedge clk); #1;
    chk("sat.frz_cnt", 64'(stall_cnt), 64'hFFFF);
    chk("sat.frz_stall", 64'(stall), 64'd1);
    @(negedge clk);
    freeze = 0;
    @(posedge clk); #1;
    chk("sat.hold", 64'(stall_cnt), 64'hFFFF);
    chk("sat.bubble", 64'(dest_EXE), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_hazard_stage.md
# id_exe_hazard_stage

ID/EXE pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It captures the decoded instruction from ID, holds the EXE-stage source/destination register numbers and control bits that the EXE forwarding unit consumes, and inserts bubbles when a dependency cannot be forwarded. It also drives the stall signal that freezes PC and IF/ID.

## Interface
- DATA_W, 32, operand/store value width
- REG_W, 5, register-file address width
- CMD_W, 4, EXE_CMD width
- CNT_W, 16, stall counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- forward_en  in  1  1: forwarding unit active; 0: stall on every RAW dependency
- flush  in  1  branch taken; squash the ID instruction
- freeze  in  1  external memory stall; hold all state
- src1_ID, src2_ID, ST_src_ID  in  REG_W each  ID-stage source registers
- two_src_ID  in  1  instruction reads src2 (R-type or store)
- dest_ID  in  REG_W  ID-stage destination
- val1_ID, val2_ID, ST_val_ID  in  DATA_W each  ID-stage operands
- EXE_CMD_ID  in  CMD_W; MEM_R_EN_ID, MEM_W_EN_ID, WB_EN_ID  in  1 each
- dest_MEM  in  REG_W; WB_EN_MEM  in  1  MEM-stage destination info
- src1_EXE, src2_EXE, ST_src_EXE, dest_EXE  out  REG_W each  registered
- val1_EXE, val2_EXE, ST_val_EXE  out  DATA_W each  registered
- EXE_CMD_EXE  out  CMD_W; MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE  out  1 each  registered
- stall  out  1  combinational; hold PC and IF/ID
- stall_cnt  out  CNT_W  registered count of bubble cycles inserted

## Operation
- Hazard terms (combinational, from ID inputs and registered EXE outputs):
  - m1 = src1_ID != 0; m2 = two_src_ID and src2_ID != 0; ms = MEM_W_EN_ID and ST_src_ID != 0.
  - hit(d, en) = en and d != 0 and ((m1 and src1_ID==d) or (m2 and src2_ID==d) or (ms and ST_src_ID==d)).
  - forward_en=1: stall = hit(dest_EXE, WB_EN_EXE) and MEM_R_EN_EXE.
  - forward_en=0: stall = hit(dest_EXE, WB_EN_EXE) or hit(dest_MEM, WB_EN_MEM).
  - WB-stage matches are never hazards (register file is write-through).
  - stall is forced to 0 while flush=1 or rst=0.
- Register update priority, per rising edge:
  1. rst=0: all outputs 0, stall_cnt=0.
  2. freeze=1: hold everything, including stall_cnt.
  3. flush=1 or stall=1: load bubble. Control bits, dest_EXE, and src*_EXE become 0; value fields are don't-care but are driven 0.
  4. Otherwise: capture all *_ID inputs into the *_EXE outputs.
- WB_EN_EXE is captured as WB_EN_ID and (dest_ID != 0), so writes to $zero never appear as forwarding sources.
- stall_cnt increments by 1 on each edge that loads a bubble because of stall (flush bubbles excluded). It saturates at all-ones, does not wrap, and clears only on reset.

## Timing
- Latency: ID inputs appear on the *_EXE outputs one cycle later.
- stall has zero latency: it is asserted in the same cycle the dependent instruction sits in ID.
- Load-use with forwarding:
  - Exactly one bubble.
  - Cycle t: load in EXE, stall=1.
  - t+1: load in MEM, bubble in EXE, stall=0.
  - t+2: dependent in EXE; the forwarding unit selects the WB path.
- forward_en=0:
  - Dependent on the immediately preceding ALU op: two bubbles.
  - Dependent on the op two ahead: one bubble.
- freeze during stall: stall stays asserted and the bubble is deferred until freeze deasserts. stall_cnt counts once per inserted bubble, not per frozen cycle.
- flush and stall together: a flush bubble is loaded, stall=0, and the counter is not incremented.
- Reset mid-stall: outputs are 0 on the next edge; stall drops once rst is sampled low.

## Test plan
- Reset: drive garbage on *_ID, rst=0 for 2 cycles -> all outputs 0, stall_cnt=0, stall=0.
- Load-use, forward_en=1: LW dest 5, then ADD src1=5 -> stall=1 for exactly 1 cycle; EXE gets 1 bubble then ADD with src1_EXE=5; stall_cnt=1.
- No-forward RAW: forward_en=0, ADD dest 3, then SUB src2=3, two_src=1 -> 2 bubble cycles, stall_cnt=2; with two_src=0 -> no stall.
- $zero: LW dest 0, then ADD src1=0 -> no stall; captured WB_EN_EXE=0.
- Flush+stall: load-use condition with flush=1 in the same cycle -> stall=0, bubble loaded, stall_cnt unchanged.
- Freeze: freeze=1 for 3 cycles during a load-use stall -> outputs held, stall=1 throughout, stall_cnt increments once after release; preload stall_cnt=16'hFFFF -> stays 16'hFFFF.
